// File: rtl/reg_file_banked.sv
// reg_file_banked
//   Banked multi-port register file. Read requests are arbitrated per bank
//   with a round-robin pointer. A request that loses arbitration is refused
//   through OUT_rready, and the requester must hold it and retry. Writes
//   never stall. A granted read of an address written in the same cycle
//   returns the winning write data. Entries that have not been written since
//   reset read as zero.
// Ports
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   IN_re/IN_raddr : per-port read request and address
//   OUT_rready     : combinational grant, asserted in the cycle of acceptance
//   OUT_rvalid     : registered, asserted one cycle after a grant
//   OUT_rdata      : registered read data, held on ports that were not granted
//   IN_we/IN_waddr/IN_wdata : write ports; the highest index wins on a clash
//   OUT_wcollision : registered pulse, two enabled writes hit one address
module reg_file_banked #(
    parameter int WIDTH       = 32,
    parameter int SIZE        = 64,
    parameter int NUM_READ    = 8,
    parameter int NUM_WRITE   = 4,
    parameter int NUM_BANKS   = 2,
    parameter int BANK_RPORTS = 2,
    parameter int ZERO_REG    = 1,
    localparam int AW         = $clog2(SIZE)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_READ-1:0]                 IN_re,
    input  logic [NUM_READ-1:0][AW-1:0]         IN_raddr,
    output logic [NUM_READ-1:0]                 OUT_rready,
    output logic [NUM_READ-1:0]                 OUT_rvalid,
    output logic [NUM_READ-1:0][WIDTH-1:0]      OUT_rdata,
    input  logic [NUM_WRITE-1:0]                IN_we,
    input  logic [NUM_WRITE-1:0][AW-1:0]        IN_waddr,
    input  logic [NUM_WRITE-1:0][WIDTH-1:0]     IN_wdata,
    output logic                                OUT_wcollision
);

    localparam int PW = (NUM_READ > 1) ? $clog2(NUM_READ) : 1;
    localparam logic [AW-1:0] BANK_MASK = AW'(NUM_BANKS - 1);

    logic [WIDTH-1:0]              mem_r [SIZE];
    logic [SIZE-1:0]               written_r;
    logic [PW-1:0]                 rr_r      [NUM_BANKS];
    logic [PW-1:0]                 rr_next_s [NUM_BANKS];
    logic [NUM_READ-1:0]           grant_s;
    logic [NUM_READ-1:0]           zero_rd_s;
    logic [NUM_WRITE-1:0]          w_eff_s;
    logic                          wcoll_s;
    logic [NUM_READ-1:0][WIDTH-1:0] rd_data_s;
    logic [NUM_READ-1:0]           rvalid_r;
    logic [NUM_READ-1:0][WIDTH-1:0] rdata_r;
    logic                          wcollision_r;

    // Detect an address-0 access that the hard-wired zero register absorbs.
    function automatic logic is_zero_addr(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == AW'(0));
    endfunction

    // Classify read ports that target the zero register (no bank slot used).
    always_comb begin
        zero_rd_s = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            if (IN_re[i] && is_zero_addr(IN_raddr[i])) begin
                zero_rd_s[i] = 1'b1;
            end else begin
                zero_rd_s[i] = 1'b0;
            end
        end
    end

    // Per-bank round-robin arbitration and pointer update; depends only on
    // read requests and rr, never on the write ports.
    always_comb begin
        grant_s = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            int  cnt;
            int  last;
            int  p;
            logic denied;
            cnt    = 0;
            last   = 0;
            denied = 1'b0;
            for (int k = 0; k < NUM_READ; k++) begin
                p = int'(rr_r[b]) + k;
                if (p >= NUM_READ) begin
                    p = p - NUM_READ;
                end else begin
                    p = p;
                end
                if (IN_re[p] && !zero_rd_s[p] &&
                    ((IN_raddr[p] & BANK_MASK) == AW'(b))) begin
                    if (cnt < BANK_RPORTS) begin
                        grant_s[p] = 1'b1;
                        last       = p;
                        cnt        = cnt + 1;
                    end else begin
                        denied = 1'b1;
                    end
                end else begin
                    denied = denied;
                end
            end
            // Restart the scan just after the last winner so losers go first.
            if (denied) begin
                if (last == NUM_READ - 1) begin
                    rr_next_s[b] = PW'(0);
                end else begin
                    rr_next_s[b] = PW'(last + 1);
                end
            end else begin
                rr_next_s[b] = rr_r[b];
            end
        end
    end

    assign OUT_rready = grant_s | zero_rd_s;

    // Effective writes (zero register drops them) and same-address collision.
    always_comb begin
        wcoll_s = 1'b0;
        for (int j = 0; j < NUM_WRITE; j++) begin
            w_eff_s[j] = IN_we[j] && !is_zero_addr(IN_waddr[j]);
        end
        for (int j = 0; j < NUM_WRITE; j++) begin
            for (int k = j + 1; k < NUM_WRITE; k++) begin
                if (w_eff_s[j] && w_eff_s[k] && (IN_waddr[j] == IN_waddr[k])) begin
                    wcoll_s = 1'b1;
                end else begin
                    wcoll_s = wcoll_s;
                end
            end
        end
    end

    // Read data: stored value (or 0 if never written), overridden by a
    // same-cycle write; the ascending loop lets the highest write port win.
    always_comb begin
        for (int i = 0; i < NUM_READ; i++) begin
            if (written_r[IN_raddr[i]]) begin
                rd_data_s[i] = mem_r[IN_raddr[i]];
            end else begin
                rd_data_s[i] = '0;
            end
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (w_eff_s[j] && (IN_waddr[j] == IN_raddr[i])) begin
                    rd_data_s[i] = IN_wdata[j];
                end else begin
                    rd_data_s[i] = rd_data_s[i];
                end
            end
            if (is_zero_addr(IN_raddr[i])) begin
                rd_data_s[i] = '0;
            end else begin
                rd_data_s[i] = rd_data_s[i];
            end
        end
    end

    // Data array, not reset; the later (higher-index) assignment wins.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (w_eff_s[j]) begin
                mem_r[IN_waddr[j]] <= IN_wdata[j];
            end
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_r     <= '0;
            rdata_r      <= '0;
            wcollision_r <= 1'b0;
            written_r    <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                rr_r[b] <= PW'(0);
            end
        end else begin
            rvalid_r     <= OUT_rready;
            wcollision_r <= wcoll_s;
            for (int i = 0; i < NUM_READ; i++) begin
                if (OUT_rready[i]) begin
                    rdata_r[i] <= rd_data_s[i];
                end
            end
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (w_eff_s[j]) begin
                    written_r[IN_waddr[j]] <= 1'b1;
                end
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                rr_r[b] <= rr_next_s[b];
            end
        end
    end

    assign OUT_rvalid     = rvalid_r;
    assign OUT_rdata      = rdata_r;
    assign OUT_wcollision = wcollision_r;

endmodule

// File: doc/reg_file_banked.md
# reg_file_banked

Multi-bank register file with arbitrated read ports, write-to-read bypass and reset-cleared entries; the next generation of the physical register file. Reads are split across `NUM_BANKS` banks, each serving at most `BANK_RPORTS` reads per cycle. Losing read requests are back-pressured with `OUT_rready` rather than relying on the scheduler to avoid conflicts. Same-cycle read/write to one address is legal and forwarded; it is no longer treated as an error.

## Interface
- `WIDTH`, 32, data width.
- `SIZE`, 64, number of entries (power of two); `AW = $clog2(SIZE)`.
- `NUM_READ`, 8, read ports.
- `NUM_WRITE`, 4, write ports.
- `NUM_BANKS`, 2, banks (power of two, ≤ `SIZE`); bank = `raddr[$clog2(NUM_BANKS)-1:0]`.
- `BANK_RPORTS`, 2, reads serviced per bank per cycle (1..`NUM_READ`).
- `ZERO_REG`, 1, if 1 entry 0 reads as 0 and ignores writes.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `IN_re`  in  `NUM_READ`  read request per port.
- `IN_raddr`  in  `NUM_READ`×`AW`  read address.
- `OUT_rready`  out  `NUM_READ`  combinational grant; request accepted this cycle.
- `OUT_rvalid`  out  `NUM_READ`  registered; data valid on `OUT_rdata[i]`.
- `OUT_rdata`  out  `NUM_READ`×`WIDTH`  registered read data.
- `IN_we`  in  `NUM_WRITE`  write enable.
- `IN_waddr`  in  `NUM_WRITE`×`AW`  write address.
- `IN_wdata`  in  `NUM_WRITE`×`WIDTH`  write data.
- `OUT_wcollision`  out  1  registered pulse: two enabled write ports hit the same address in the previous cycle.

## Operation
- **Storage.** `mem[SIZE]` holds data (not reset). `written[SIZE]` holds one bit per entry, cleared by reset. A read of an entry with `written=0` returns 0.
- **Writes.** Writes never stall. Each enabled port writes `mem[waddr]` and sets `written[waddr]`.
  - If several ports target one address, the highest port index wins.
  - The same condition sets `OUT_wcollision` for one cycle.
  - With `ZERO_REG=1`, writes to address 0 are dropped and excluded from collision detection.
- **Read arbitration.** Arbitration is per bank, with a round-robin pointer `rr[b]` (0..`NUM_READ-1`).
  - Scan ports `rr[b]`, `rr[b]+1`, … modulo `NUM_READ`.
  - Grant the first `BANK_RPORTS` ports with `IN_re` set and mapping to bank `b`.
  - `OUT_rready[i]` = granted. `OUT_rready[i]` for an idle port is 0.
- **Zero register.** With `ZERO_REG=1`, address-0 reads are always granted, consume no bank slot, and return 0.
- **Pointer update.** If any request in bank `b` was denied this cycle, `rr[b]` ← (index of last granted port in `b`) + 1 mod `NUM_READ`. Otherwise `rr[b]` is unchanged.
- **Denied requests.** A denied port must hold `IN_re`/`IN_raddr` and retry. The block keeps no state for it.
- **Bypass.** A read granted in cycle t of an address written in cycle t returns the winning write data from t (highest write index).
- **Data for non-granted ports.** Ports not granted get `OUT_rvalid=0`, and `OUT_rdata` holds its previous value.

## Timing
- Read latency is 1 cycle: grant at edge t gives `OUT_rvalid`/`OUT_rdata` after edge t+1.
- A write at edge t is visible to same-cycle granted reads (bypass) and to all later reads.
- `OUT_rready` depends combinationally on `IN_re`, `IN_raddr` and `rr` only, never on write inputs.
- Reset (asynchronous assert, synchronous release):
  - `OUT_rvalid` = 0, `OUT_rdata` = 0, `OUT_wcollision` = 0.
  - `rr[*]` = 0, `written[*]` = 0.
  - Writes and grants in the cycle reset asserts are discarded.
- Reset mid-operation: data in flight is lost and `OUT_rvalid` drops immediately. After release, every entry reads 0 until rewritten.
- Boundaries:
  - `BANK_RPORTS ≥` requests in a bank: all are granted and the pointer holds.
  - `rr` wraps from `NUM_READ-1` to 0.
  - Address `SIZE-1` maps to bank `NUM_BANKS-1`.

## Test plan
- **Post-reset read.** Reset, then read addresses 5 and 63 on ports 0/1 → rready=11, next cycle rvalid=11, rdata=0/0.
- **Bypass and write collision.** Cycle t: write port 1 addr 6 = 0xAAAA, write port 3 addr 6 = 0xBBBB, read port 2 addr 6 → t+1: rdata[2]=0xBBBB, `OUT_wcollision`=1. At t+2 `OUT_wcollision` is 0.
- **Bank conflict, round-robin.** `NUM_BANKS`=2, `BANK_RPORTS`=2. Ports 0,1,2,3 all read even addresses every cycle.
  - Cycle 1 grants 0,1.
  - Cycle 2 grants 2,3.
  - Cycle 3 grants 0,1.
  - Denied ports have rvalid=0 in the following cycle.
- **Zero register.** `ZERO_REG`=1: write addr 0 = 0x1234, then 4 ports read addr 0 plus 2 ports read addr 2 (bank 0) → all 6 granted, rdata=0 for addr-0 reads.
- **Reset mid-stream.** Write addr 10 = 0x55, grant a read of 10, assert `rst_n` before the next edge → rvalid=0 at once. After release, a read of 10 returns 0.
- **Randomised check.** 10k cycles of random reads/writes against a scoreboard model (including bypass, collisions and held denied requests) → every rvalid data matches and no granted request is lost.
